// File: rtl/exp_seq_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package exp_seq_pkg;

  localparam int WORDS   = 16;
  localparam int NUM_OPS = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_X      = 3'd0,
    SEL_M      = 3'd1,
    SEL_E      = 3'd2,
    SEL_RMODM  = 3'd3,
    SEL_R2MODM = 3'd4
  } sel_t;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel <= 3'd4;
  endfunction

endpackage

// File: rtl/exp_seq_res_ser.sv
// Result serializer: holds the core result and hands it out one word per
// handshake, least-significant word first.
module exp_seq_res_ser
  import exp_seq_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int OP_W   = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [OP_W-1:0]   load_data,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [WORD_W-1:0] res_data,
  output logic              res_last,
  output logic              last_xfer
);

  logic [OP_W-1:0] shift_q;
  logic [3:0]      cnt_q;
  logic            valid_q;
  logic            xfer;

  assign xfer = valid_q & res_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      shift_q <= shift_q >> WORD_W;
      cnt_q   <= cnt_q + 4'd1;
      if (cnt_q == 4'(WORDS - 1)) valid_q <= 1'b0;
    end
  end

  assign res_valid = valid_q;
  assign res_data  = shift_q[WORD_W-1:0];
  assign res_last  = valid_q & (cnt_q == 4'(WORDS - 1));
  assign last_xfer = xfer & res_last;

endmodule

// File: rtl/exp_sequencer.sv
// Operand loader and run sequencer for a modular-exponentiation core.
// Optional watchdog on the RUN state: define EXP_SEQ_TIMEOUT_EN.
module exp_sequencer
  import exp_seq_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int OP_W        = 512,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_sel,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              go,
  input  logic              mul_only,
  output logic              busy,
  output logic              err,
  output logic              core_start,
  output logic              core_mul_en,
  output logic [OP_W-1:0]   core_x,
  output logic [OP_W-1:0]   core_m,
  output logic [OP_W-1:0]   core_e,
  output logic [OP_W-1:0]   core_rmodm,
  output logic [OP_W-1:0]   core_r2modm,
  input  logic              core_done,
  input  logic [OP_W-1:0]   core_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              res_last
);

  state_t               state_q, state_d;
  logic [OP_W-1:0]      op_q [NUM_OPS];
  logic [3:0]           beat_q;
  logic [2:0]           sel_q;
  logic [NUM_OPS-1:0]   mask_q;
  logic                 err_q;
  logic                 mul_en_q;
  logic                 ld_acc, beat_ok, go_acc, go_bad;
  logic                 load_ser, last_xfer, tmo_hit;

  assign ld_ready = (state_q == ST_IDLE) & ~go;
  assign ld_acc   = ld_valid & ld_ready;
  assign beat_ok  = sel_legal(ld_sel) & ((beat_q == 4'd0) | (ld_sel == sel_q));
  assign go_acc   = go & (state_q == ST_IDLE) & (&mask_q) & (beat_q == 4'd0);
  assign go_bad   = go & (state_q == ST_IDLE) & ~go_acc;

  // A burst starting on an operand invalidates it until its 16th beat lands,
  // so an aborted burst leaves the mask bit clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      beat_q <= '0;
      sel_q  <= '0;
      mask_q <= '0;
    end else if (ld_acc) begin
      if (beat_ok) begin
        op_q[ld_sel] <= {ld_data, op_q[ld_sel][OP_W-1:WORD_W]};
        beat_q       <= beat_q + 4'd1;
        if (beat_q == 4'd0) begin
          sel_q          <= ld_sel;
          mask_q[ld_sel] <= 1'b0;
        end
        if (beat_q == 4'(WORDS - 1)) mask_q[sel_q] <= 1'b1;
      end else begin
        beat_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      mul_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go_acc) begin
        err_q    <= 1'b0;
        mul_en_q <= mul_only;
      end else if (go_bad | (ld_acc & ~beat_ok) | tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load_ser = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (go_acc) state_d = ST_RUN;
      ST_RUN: begin
        if (core_done) begin
          state_d  = ST_UNLOAD;
          load_ser = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_UNLOAD: if (last_xfer) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                tmo_q <= '0;
    else if (state_q != ST_RUN) tmo_q <= '0;
    else                        tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == ST_RUN) & ~core_done & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: constant zero.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  exp_seq_res_ser #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W)
  ) u_res_ser (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load_ser),
    .load_data (core_result),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_last  (res_last),
    .last_xfer (last_xfer)
  );

  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign core_start  = (state_q == ST_RUN);
  assign core_mul_en = mul_en_q;
  assign core_x      = op_q[SEL_X];
  assign core_m      = op_q[SEL_M];
  assign core_e      = op_q[SEL_E];
  assign core_rmodm  = op_q[SEL_RMODM];
  assign core_r2modm = op_q[SEL_R2MODM];

endmodule

// File: tb/tb_exp_sequencer.sv
// Scoreboard bench for exp_sequencer with a stub exponentiation core.
module tb_exp_sequencer;

  localparam int WORD_W = 32;
  localparam int OP_W   = 512;
`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 1048576;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              ld_valid, ld_ready, go, mul_only, busy, err;
  logic [2:0]        ld_sel;
  logic [WORD_W-1:0] ld_data, res_data;
  logic              core_start, core_mul_en, core_done;
  logic [OP_W-1:0]   core_x, core_m, core_e, core_rmodm, core_r2modm, core_result;
  logic              res_valid, res_ready, res_last;

  exp_sequencer #(.WORD_W(WORD_W), .OP_W(OP_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sel(ld_sel), .ld_data(ld_data), .go(go), .mul_only(mul_only),
    .busy(busy), .err(err), .core_start(core_start), .core_mul_en(core_mul_en),
    .core_x(core_x), .core_m(core_m), .core_e(core_e), .core_rmodm(core_rmodm),
    .core_r2modm(core_r2modm), .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WORD_W:0] exp_q[$];
  logic [WORD_W:0] mon_w;

  task automatic check(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (resetn && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_extra: got last=%0b data=%h with nothing expected", res_last, res_data);
      end else begin
        mon_w = exp_q.pop_front();
        if ({res_last, res_data} !== mon_w) begin
          errors++;
          $display("FAIL res_word: got last=%0b data=%h want last=%0b data=%h",
                   res_last, res_data, mon_w[WORD_W], mon_w[WORD_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OP_W-1:0] mk(input logic [31:0] hi, input logic [31:0] lo,
                                        input logic [31:0] seed);
    logic [OP_W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = (seed * 32'(i + 1)) ^ (32'(i) << 24);
    v[31:0]    = lo;
    v[511:480] = hi;
    return v;
  endfunction

  task automatic load_op(input logic [2:0] sel, input logic [OP_W-1:0] val);
    for (int i = 0; i < 16; i++) begin
      ld_sel   = sel;
      ld_data  = val[i*32 +: 32];
      ld_valid = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic do_go(input logic mo);
    go       = 1'b1;
    mul_only = mo;
    #1;
    check("ld_ready_during_go", ld_ready, 0);
    tick();
    go = 1'b0;
  endtask

  logic [OP_W-1:0] xv, mv, ev, rmv, r2v, resv;
  logic [31:0]     rw [16];
  int              n, hold_n;
  logic            stalled, saw_valid;

  initial begin
    ld_valid = 0; ld_sel = 0; ld_data = 0; go = 0; mul_only = 0;
    core_done = 0; core_result = '0; res_ready = 0;
    xv  = mk(32'hd536a1c7, 32'h5e9102b2, 32'h9e3779b9);
    mv  = mk(32'hf21e0b35, 32'h8c27df4d, 32'h7f4a7c15);
    ev  = 512'hb7;
    rmv = mk(32'h0de1c2a9, 32'h33f720b3, 32'h85ebca6b);
    r2v = mk(32'hcb8a5d12, 32'h6a0419d4, 32'hc2b2ae35);
    rw = '{32'h4f8c3c3e, 32'h27182818, 32'h31415926, 32'hfedcba98,
           32'h76543210, 32'habcdef01, 32'h24681357, 32'h8f7e6d5c,
           32'h1d2c3b4a, 32'he3c2a1b0, 32'h5b7a9988, 32'h0f2e4d6c,
           32'hc8e1a253, 32'h6b3d7f40, 32'h9a0c5e21, 32'h73f84efd};
    for (int i = 0; i < 16; i++) resv[i*32 +: 32] = rw[i];

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_core_start", core_start, 0);
    check("rst_mul_en", core_mul_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_last", res_last, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_core_x", core_x, 0);

    // go with only four operands loaded
    load_op(3'd0, xv);
    load_op(3'd1, mv);
    load_op(3'd2, ev);
    load_op(3'd3, rmv);
    do_go(1'b0);
    check("go4_err", err, 1);
    check("go4_busy", busy, 0);
    check("go4_core_start", core_start, 0);

    // ld_sel switches mid-burst, modulus must be invalidated
    load_op(3'd4, r2v);
    for (int i = 0; i < 7; i++) begin
      ld_sel = 3'd1; ld_data = 32'h11110000 + 32'(i); ld_valid = 1'b1;
      tick();
    end
    ld_sel = 3'd2; ld_data = 32'hdeadbeef;
    tick();
    ld_valid = 1'b0;
    check("selswitch_err", err, 1);
    do_go(1'b0);
    check("selswitch_go_busy", busy, 0);
    load_op(3'd1, mv);

    // full run with stalls
    do_go(1'b1);
    check("run_busy", busy, 1);
    check("run_err_cleared", err, 0);
    check("run_mul_en", core_mul_en, 1);
    check("run_core_start", core_start, 1);
    check("op_x", core_x, xv);
    check("op_m", core_m, mv);
    check("op_e", core_e, ev);
    check("op_rmodm", core_rmodm, rmv);
    check("op_r2modm", core_r2modm, r2v);
    check("ld_ready_run", ld_ready, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_in_run_err", err, 0);
    check("go_in_run_busy", busy, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), rw[i]});
    tick();
    core_result = resv;
    core_done   = 1'b1;
    tick();
    core_done = 1'b0;
    check("done_core_start", core_start, 0);
    check("done_res_valid", res_valid, 1);
    check("done_busy", busy, 1);
    res_ready = 1'b1; n = 0; stalled = 1'b0;
    for (int c = 0; c < 100 && n < 16; c++) begin
      if (n == 6 && !stalled) begin
        stalled = 1'b1;
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_valid", res_valid, 1);
          check("stall_data", res_data, rw[6]);
        end
        res_ready = 1'b1;
      end
      if (res_valid) n++;
      tick();
    end
    res_ready = 1'b0;
    check("unload_count", n, 16);
    check("unload_res_valid", res_valid, 0);
    check("unload_busy", busy, 0);
    check("unload_queue_empty", exp_q.size(), 0);

    // operands persist; reset aborts a run
    do_go(1'b0);
    check("run2_busy", busy, 1);
    check("run2_mul_en", core_mul_en, 0);
    tick();
    #2 resetn = 1'b0;
    #1;
    check("arst_core_start", core_start, 0);
    check("arst_busy", busy, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_ld_ready", ld_ready, 1);
    check("arst_core_m", core_m, 0);
    tick();
    resetn = 1'b1;
    ld_sel = 3'd5; ld_data = 32'h12345678; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    check("illegal_sel_err", err, 1);
    do_go(1'b0);
    check("go_after_rst_err", err, 1);
    check("go_after_rst_busy", busy, 0);

`ifdef EXP_SEQ_TIMEOUT_EN
    load_op(3'd0, xv);
    load_op(3'd1, mv);
    load_op(3'd2, ev);
    load_op(3'd3, rmv);
    load_op(3'd4, r2v);
    do_go(1'b0);
    check("tmo_enter_busy", busy, 1);
    hold_n = 0; saw_valid = 1'b0;
    for (int c = 0; c < 200 && busy; c++) begin
      tick();
      hold_n++;
      if (res_valid) saw_valid = 1'b1;
    end
    check("tmo_cycles", hold_n, TMO);
    check("tmo_err", err, 1);
    check("tmo_core_start", core_start, 0);
    check("tmo_no_result", saw_valid, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
